reset_sequencer: RTL



---
 rtl/reset_sequencer_if.sv | 14 +
 rtl/reset_sequencer.sv | 97 +++++++++
 2 files changed

// File: rtl/reset_sequencer_if.sv
// reset_sequencer_if: clock-lock/request inputs and sequenced reset outputs of reset_sequencer
// locked: async clock-stable flag; sw_rst_req: sync level request
// rst_out: per-stage active-high resets; rstn_out: global active-low reset
// seq_done: all stages released; state: WAIT_LOCK=0 RELEASE=1 RUN=2 HOLD=3
interface reset_sequencer_if #(parameter int NUM_STAGES = 4);
  logic                  locked;
  logic                  sw_rst_req;
  logic [NUM_STAGES-1:0] rst_out;
  logic                  rstn_out;
  logic                  seq_done;
  logic [1:0]            state;
  modport master (output locked, sw_rst_req, input rst_out, rstn_out, seq_done, state);
  modport slave (input locked, sw_rst_req, output rst_out, rstn_out, seq_done, state);
endinterface

// File: rtl/reset_sequencer.sv
// reset_sequencer: filters clock lock, then releases stage resets in ascending order with fixed spacing
// clk/rst_n: system clock and async active-low reset
// bus (slave): locked, sw_rst_req in; rst_out, rstn_out, seq_done, state out
module reset_sequencer #(
  parameter int NUM_STAGES  = 4,
  parameter int LOCK_FILTER = 8,
  parameter int STAGE_DELAY = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int SYNC_STAGES = 2
) (
  input logic               clk,
  input logic               rst_n,
  reset_sequencer_if.slave  bus
);
  typedef enum logic [1:0] {WAIT_LOCK, RELEASE, RUN, HOLD} state_t;
  localparam int M1 = LOCK_FILTER > STAGE_DELAY ? LOCK_FILTER : STAGE_DELAY;
  localparam int MAXC = M1 > HOLD_CYCLES ? M1 : HOLD_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  localparam int SW = NUM_STAGES > 1 ? $clog2(NUM_STAGES) : 1;
  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [SW-1:0]          stage_q, stage_d;
  logic [NUM_STAGES-1:0]  rst_out_q, rst_out_d;
  logic                   seq_done_q, seq_done_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   lock_s, fault;
  assign lock_s = sync_q[SYNC_STAGES-1];
  assign fault = !lock_s || bus.sw_rst_req;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    stage_d = stage_q;
    rst_out_d = rst_out_q;
    seq_done_d = seq_done_q;
    sync_d = {sync_q[SYNC_STAGES-2:0], bus.locked};
    case (state_q)
      WAIT_LOCK: begin
        cnt_d = fault ? '0 : cnt_q + 1'b1;
        if (!fault && cnt_q == CW'(LOCK_FILTER - 1)) begin
          state_d = RELEASE;
          cnt_d = '0;
          stage_d = '0;
        end
      end
      RELEASE: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(STAGE_DELAY - 1)) begin
          rst_out_d = rst_out_q & ~(NUM_STAGES'(1) << stage_q);
          stage_d = stage_q + 1'b1;
          cnt_d = '0;
          if (stage_q == SW'(NUM_STAGES - 1)) begin
            state_d = RUN;
            seq_done_d = 1'b1;
          end
        end
      end
      HOLD: begin
        // a held request keeps restarting the minimum hold window
        cnt_d = bus.sw_rst_req ? '0 : cnt_q + 1'b1;
        if (!bus.sw_rst_req && cnt_q == CW'(HOLD_CYCLES - 1)) begin
          state_d = WAIT_LOCK;
          cnt_d = '0;
        end
      end
      default: ;
    endcase
    // fault overrides any release due on the same edge
    if (fault && (state_q == RELEASE || state_q == RUN)) begin
      state_d = HOLD;
      rst_out_d = '1;
      seq_done_d = 1'b0;
      cnt_d = '0;
      stage_d = '0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WAIT_LOCK;
      cnt_q <= '0;
      stage_q <= '0;
      rst_out_q <= '1;
      seq_done_q <= 1'b0;
      sync_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      stage_q <= stage_d;
      rst_out_q <= rst_out_d;
      seq_done_q <= seq_done_d;
      sync_q <= sync_d;
    end
  end
  assign bus.rst_out = rst_out_q;
  assign bus.rstn_out = ~rst_out_q[NUM_STAGES-1];
  assign bus.seq_done = seq_done_q;
  assign bus.state = state_q;
endmodule
